instr_fetcher: RTL and testbench

//   Per-core instruction fetch stage, directly upstream of the instruction decoder.
//   On core_state==FETCH it requests the word at current_pc from program memory via
//   a valid/ready handshake and holds it on `instruction` for the decoder.
//   A bounded wait watchdog substitutes RET on a hung memory so the core terminates.

---
 rtl/instr_fetcher.sv | 114 +++++++++++
 tb/tb_instr_fetcher.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetcher.sv
// Instruction fetch stage: issues one program-memory read per FETCH, holds the word for the
// decoder, and substitutes RET if memory never answers within TIMEOUT_CYCLES.
module instr_fetcher #(
    parameter int unsigned PROGRAM_ADDR_WIDTH = 8,
    parameter int unsigned INSTR_WIDTH        = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    core_state,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] current_pc,
    output logic                          mem_read_valid,
    output logic [PROGRAM_ADDR_WIDTH-1:0] mem_read_address,
    input  logic                          mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]        mem_read_data,
    output logic [1:0]                    fetcher_state,
    output logic [INSTR_WIDTH-1:0]        instruction,
    output logic                          fetch_error
);

    localparam logic [2:0] CoreFetch  = 3'b001;
    localparam logic [2:0] CoreDecode = 3'b010;
    localparam logic [3:0] OpcodeRet  = 4'hF;

    localparam bit          WdEnable = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CntWidth = WdEnable ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CntWidth-1:0] CntMax      = '1;
    localparam logic [CntWidth-1:0] TimeoutLast =
        WdEnable ? CntWidth'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFetching = 2'd1,
        StFetched  = 2'd2
    } fetch_state_e;

    fetch_state_e                  state_q, state_d;
    logic                          valid_q, valid_d;
    logic [PROGRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INSTR_WIDTH-1:0]        instr_q, instr_d;
    logic                          err_q, err_d;
    logic [CntWidth-1:0]           cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (core_state == CoreFetch) begin
                    valid_d = 1'b1;
                    addr_d  = current_pc;
                    cnt_d   = '0;
                    state_d = StFetching;
                end
            end
            StFetching: begin
                // Returned data wins over a watchdog expiry on the same edge.
                if (mem_read_ready) begin
                    instr_d = mem_read_data;
                    valid_d = 1'b0;
                    state_d = StFetched;
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                    if (WdEnable && (cnt_q == TimeoutLast)) begin
                        instr_d = {OpcodeRet, {(INSTR_WIDTH - 4){1'b0}}};
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        state_d = StFetched;
                    end
                end
            end
            StFetched: begin
                if (core_state == CoreDecode) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;
    assign fetch_error      = err_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// Bench for instr_fetcher: directed and randomized fetch transactions, each predicted from a
// wait-count model (data if ready arrives within the timeout window, else RET + sticky error).
module tb_instr_fetcher;

    localparam int unsigned T = 8;
    localparam logic [2:0] CsFetch   = 3'b001;
    localparam logic [2:0] CsDecode  = 3'b010;
    localparam logic [2:0] CsExecute = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [1:0]  fetcher_state;
    logic [15:0] instruction;
    logic        fetch_error;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_instr;
    logic        exp_err;

    instr_fetcher #(
        .PROGRAM_ADDR_WIDTH(8),
        .INSTR_WIDTH       (16),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core_state      (core_state),
        .current_pc      (current_pc),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .fetcher_state   (fetcher_state),
        .instruction     (instruction),
        .fetch_error     (fetch_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_state", 32'(fetcher_state), 32'd0);
        check("rst_valid", 32'(mem_read_valid), 32'd0);
        check("rst_addr", 32'(mem_read_address), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_err", 32'(fetch_error), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values();
        exp_instr = 16'h0000;
        exp_err   = 1'b0;
    endtask

    // Ready is raised during FETCHING cycle wait_n (0 = first cycle); wait_n >= T never answers.
    task automatic do_fetch(input logic [7:0] pc, input int wait_n, input logic [15:0] data);
        bit done;
        core_state     = CsFetch;
        current_pc     = pc;
        mem_read_ready = 1'b0;
        step();
        check("req_valid", 32'(mem_read_valid), 32'd1);
        check("req_addr", 32'(mem_read_address), 32'(pc));
        check("req_state", 32'(fetcher_state), 32'd1);
        done = 1'b0;
        for (int i = 0; i < int'(T) && !done; i++) begin
            current_pc     = 8'($urandom);
            mem_read_ready = (i == wait_n);
            mem_read_data  = (i == wait_n) ? data : 16'($urandom);
            step();
            if (i == wait_n) begin
                exp_instr = data;
                done      = 1'b1;
            end else if (i == int'(T) - 1) begin
                exp_instr = 16'hF000;
                exp_err   = 1'b1;
                done      = 1'b1;
            end else begin
                check("wait_valid", 32'(mem_read_valid), 32'd1);
                check("wait_addr", 32'(mem_read_address), 32'(pc));
                check("wait_state", 32'(fetcher_state), 32'd1);
            end
        end
        mem_read_ready = 1'b0;
        check("done_state", 32'(fetcher_state), 32'd2);
        check("done_valid", 32'(mem_read_valid), 32'd0);
        check("done_instr", 32'(instruction), 32'(exp_instr));
        check("done_err", 32'(fetch_error), 32'(exp_err));
        // Stay in FETCHED without DECODE; stray ready must not disturb the held word.
        core_state     = CsExecute;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'($urandom);
        step();
        check("hold_state", 32'(fetcher_state), 32'd2);
        check("hold_instr", 32'(instruction), 32'(exp_instr));
        core_state     = CsDecode;
        mem_read_ready = 1'b0;
        step();
        check("dec_state", 32'(fetcher_state), 32'd0);
        check("dec_instr", 32'(instruction), 32'(exp_instr));
        check("dec_valid", 32'(mem_read_valid), 32'd0);
        check("dec_err", 32'(fetch_error), 32'(exp_err));
    endtask

    task automatic idle_cycle();
        core_state     = CsExecute;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'($urandom);
        step();
        mem_read_ready = 1'b0;
        check("idle_state", 32'(fetcher_state), 32'd0);
        check("idle_valid", 32'(mem_read_valid), 32'd0);
        check("idle_instr", 32'(instruction), 32'(exp_instr));
    endtask

    initial begin
        rst            = 1'b1;
        core_state     = 3'b000;
        current_pc     = 8'h00;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        exp_instr      = 16'h0000;
        exp_err        = 1'b0;
        step();
        do_reset();

        // zero-wait fetch
        do_fetch(8'h05, 0, 16'h3123);
        // wait states with pc toggling, back-to-back after DECODE
        do_fetch(8'h2A, 4, 16'hA5C3);
        idle_cycle();
        // ready on the last watchdog cycle still captures real data
        do_fetch(8'h40, int'(T) - 1, 16'h1BEE);
        // hung memory, then error persists across the next good fetch
        do_fetch(8'h77, 100, 16'hDEAD);
        do_fetch(8'h78, 2, 16'h4242);

        // reset mid-FETCHING abandons the request
        core_state = CsFetch;
        current_pc = 8'h99;
        step();
        check("mid_valid", 32'(mem_read_valid), 32'd1);
        step();
        step();
        do_reset();
        do_fetch(8'h9A, 1, 16'h7E01);

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 2) == 0) begin
                idle_cycle();
            end
            do_fetch(8'($urandom), int'($urandom_range(0, T + 2)), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
